// File: rtl/pll_drp_master.sv
// PLL DRP initiator: read / write / read-modify-write sequencing onto the
// DRP strobes, with ready timeout and generation of the PLL DRP reset.
module pll_drp_master #(
  parameter int TIMEOUT_CYC = 64,
  parameter int RSTN_HOLD   = 4
) (
  input  logic       drp_clk,
  input  logic       drp_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       drp_rstn,
  output logic       drp_sel,
  output logic       drp_rd,
  output logic       drp_wr,
  output logic [7:0] drp_addr,
  output logic [7:0] drp_wdata,
  input  logic       drp_rdy,
  input  logic       drp_err,
  input  logic [7:0] drp_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MODIFY,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] HOLD_LAST = 4'(RSTN_HOLD - 1);

  state_t     state;
  logic       rmw_q;
  logic [7:0] wdata_q;
  logic [7:0] mask_q;
  logic [7:0] rdata_q;
  logic [7:0] wait_cnt;
  logic [3:0] hold_cnt;

  logic rstn_nxt;
  logic accept;
  logic timed_out;

  assign rstn_nxt  = drp_rstn | (hold_cnt == HOLD_LAST);
  assign accept    = cmd_valid & cmd_ready;
  assign timed_out = (wait_cnt == TO_LAST);

  always_ff @(posedge drp_clk or posedge drp_rst) begin
    if (drp_rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      drp_rstn    <= 1'b0;
      drp_sel     <= 1'b0;
      drp_rd      <= 1'b0;
      drp_wr      <= 1'b0;
      drp_addr    <= 8'h00;
      drp_wdata   <= 8'h00;
      rmw_q       <= 1'b0;
      wdata_q     <= 8'h00;
      mask_q      <= 8'h00;
      rdata_q     <= 8'h00;
      wait_cnt    <= 8'h00;
      hold_cnt    <= 4'h0;
    end else begin
      drp_rstn  <= rstn_nxt;
      if (!drp_rstn) hold_cnt <= hold_cnt + 4'd1;
      rsp_valid <= 1'b0;
      drp_rd    <= 1'b0;
      drp_wr    <= 1'b0;

      unique case (state)
        IDLE: begin
          cmd_ready <= rstn_nxt;
          if (accept) begin
            cmd_ready <= 1'b0;
            rmw_q     <= cmd_op[1];
            wdata_q   <= cmd_wdata;
            mask_q    <= cmd_mask;
            rdata_q   <= 8'h00;
            unique case (cmd_op)
              2'b00, 2'b10: begin
                state    <= RD_REQ;
                drp_sel  <= 1'b1;
                drp_rd   <= 1'b1;
                drp_addr <= cmd_addr;
              end
              2'b01: begin
                state     <= WR_REQ;
                drp_sel   <= 1'b1;
                drp_wr    <= 1'b1;
                drp_addr  <= cmd_addr;
                drp_wdata <= cmd_wdata;
              end
              default: begin
                state       <= DONE;
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= 8'h00;
              end
            endcase
          end
        end

        RD_REQ: begin
          state    <= RD_WAIT;
          wait_cnt <= 8'h00;
        end

        RD_WAIT: begin
          if (drp_rdy) begin
            rdata_q <= drp_rdata;
            drp_sel <= 1'b0;
            // a failed read never proceeds to the write half of an RMW
            if (drp_err || !rmw_q) begin
              state       <= DONE;
              rsp_valid   <= 1'b1;
              rsp_err     <= drp_err;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= drp_rdata;
            end else begin
              state <= MODIFY;
            end
          end else if (timed_out) begin
            state       <= DONE;
            drp_sel     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= 8'h00;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        MODIFY: begin
          state     <= WR_REQ;
          drp_sel   <= 1'b1;
          drp_wr    <= 1'b1;
          drp_wdata <= (rdata_q & ~mask_q) | (wdata_q & mask_q);
        end

        WR_REQ: begin
          state    <= WR_WAIT;
          wait_cnt <= 8'h00;
        end

        WR_WAIT: begin
          if (drp_rdy) begin
            state       <= DONE;
            drp_sel     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= drp_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= rdata_q;
          end else if (timed_out) begin
            state       <= DONE;
            drp_sel     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= rdata_q;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= rstn_nxt;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pll_drp_master.md
Name: pll_drp_master

Overview:
Initiator for the PLL dynamic reconfiguration port (DRP). It accepts single-register commands from user logic: read, write, or read-modify-write. It sequences them onto the DRP select/read/write strobes and waits for the PLL's ready. It returns read data and error/timeout status, and it also generates the DRP reset (drp_rstn) for the PLL.

Parameters:
TIMEOUT_CYC, 64, wait cycles for drp_rdy before the access is aborted as timed out (legal range 2..255)
RSTN_HOLD, 4, drp_clk cycles drp_rstn stays low after drp_rst deasserts (legal range 1..15)

Ports:
drp_clk  in  1  DRP clock; all logic is on its rising edge
drp_rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 read, 01 write, 10 read-modify-write, 11 reserved
cmd_addr  in  8  DRP register address
cmd_wdata  in  8  write data
cmd_mask  in  8  RMW bit mask (1 = take bit from cmd_wdata)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  8  read data (valid with rsp_valid)
rsp_err  out  1  error flag (valid with rsp_valid)
rsp_timeout  out  1  timeout flag (valid with rsp_valid)
drp_rstn  out  1  DRP reset to the PLL, active-low
drp_sel  out  1  DRP select
drp_rd  out  1  read strobe
drp_wr  out  1  write strobe
drp_addr  out  8  DRP address
drp_wdata  out  8  DRP write data
drp_rdy  in  1  responder done, one-cycle pulse
drp_err  in  1  responder error, qualified by drp_rdy
drp_rdata  in  8  responder read data, qualified by drp_rdy

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, including drp_rstn and cmd_ready; the FSM is in IDLE.
  - After release, drp_rstn stays 0 for RSTN_HOLD cycles, then goes to 1 and stays there.
- States: IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - cmd_ready = drp_rstn.
  - On accept, cmd_op/addr/wdata/mask are captured.
  - Next state: op 00 → RD_REQ; op 01 → WR_REQ; op 10 → RD_REQ; op 11 → DONE with rsp_err=1 and no DRP access.
- cmd_ready is 0 in every state other than IDLE.
- RD_REQ (one cycle): drp_sel=1, drp_rd=1, drp_addr=captured address. Next state is RD_WAIT.
- RD_WAIT:
  - drp_sel=1, drp_rd=0.
  - On drp_rdy: capture drp_rdata and drp_err.
    - If drp_err=1 → DONE with err=1; an RMW is aborted and no write is issued.
    - Otherwise a read goes to DONE and an RMW goes to MODIFY.
- MODIFY (one cycle): write value = (read_data & ~mask) | (wdata & mask), computed 8-bit bitwise. Next state is WR_REQ.
- WR_REQ (one cycle): drp_sel=1, drp_wr=1, drp_addr, drp_wdata driven. Next state is WR_WAIT.
- WR_WAIT:
  - drp_sel=1.
  - On drp_rdy: capture drp_err, then go to DONE.
- Timeout:
  - An 8-bit counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle without drp_rdy.
  - When the count reaches TIMEOUT_CYC → DONE with rsp_err=1 and rsp_timeout=1.
  - If drp_rdy arrives in the same cycle the count reaches TIMEOUT_CYC, the rdy wins and there is no timeout.
- DONE (one cycle):
  - rsp_valid=1, drp_sel=0. Next state is IDLE.
  - rsp_rdata = read value for a read, original (pre-modify) value for an RMW, 0x00 for a write, reserved op or error-before-read.
- drp_rdy arriving in any state other than RD_WAIT/WR_WAIT is ignored.
- Latency:
  - Accept at cycle T → request at T+1.
  - If rdy arrives at cycle R (R ≥ T+2), rsp_valid is at R+1 for a read or write.
  - For an RMW, the write request is at R+2 and rsp_valid is 1 cycle after the write's rdy.
  - cmd_ready returns the cycle after rsp_valid.
- drp_addr and drp_wdata hold their last value when drp_sel=0. rd and wr are never both 1.
- Reset mid-operation: everything returns to the reset state immediately, and drp_rstn re-enters its hold sequence.

Test Plan:
- Reset release, RSTN_HOLD=4 → drp_rstn and cmd_ready rise exactly 4 cycles after drp_rst falls; all other outputs stay 0.
- Read addr 0x12, responder returns 0xA5 with rdy 3 cycles after the strobe → one drp_rd pulse; rsp_valid with rsp_rdata=0xA5, err=0, timeout=0.
- RMW addr 0x20, read 0xF0, wdata 0x0F, mask 0x3C → drp_wdata=0xCC on the write strobe; rsp_rdata=0xF0, err=0.
- RMW where the read returns drp_err=1 → no drp_wr issued; rsp_valid with err=1, timeout=0.
- Write with drp_rdy never asserted, TIMEOUT_CYC=64 → rsp_valid 64 wait cycles later with err=1, timeout=1; the next command is accepted normally.
- Reserved op 11, plus a stray drp_rdy in IDLE → no DRP strobes; rsp_err=1 one cycle after accept; the stray rdy causes no response.
